radix2_div32: RTL and testbench

//  Iterative restoring divider for the RV32M extension: DIV/DIVU/REM/REMU.

---
 rtl/rv32m_pkg.sv | 20 ++
 rtl/flex_counter_mul.sv | 43 ++++
 rtl/radix2_div32.sv | 200 ++++++++++++++++++++
 tb/tb_radix2_div32.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// -----------------------------------------------------------------------------
// rv32m_pkg
//   Shared types and constants for the RV32M extension blocks.
//   div_state_t   : divider FSM states
//   DIV_WIDTH     : default operand/result width
//   DIV_ZERO_QUO  : quotient returned for division by zero (all ones)
//   DIV_OVF_QUO   : quotient returned for signed overflow (most negative value)
//   DIV_OVF_REM   : remainder returned for signed overflow (zero)
// -----------------------------------------------------------------------------
package rv32m_pkg;

   typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} div_state_t;

   localparam int DIV_WIDTH = 32;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;
   localparam logic [DIV_WIDTH-1:0] DIV_OVF_QUO  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
   localparam logic [DIV_WIDTH-1:0] DIV_OVF_REM  = '0;

endpackage

// File: rtl/flex_counter_mul.sv
// -----------------------------------------------------------------------------
// flex_counter_mul
//   Clearable up-counter with programmable rollover, shared with the multiplier.
//   CLK, nRST      : clock (rising edge), asynchronous active-low reset
//   clear          : synchronous clear to zero (wins over count_enable)
//   count_enable   : advance the count by one this cycle
//   rollover_val   : terminal count
//   rollover_flag  : high in the enabled cycle whose edge brings the count to
//                    rollover_val; the count wraps to zero on that edge
// -----------------------------------------------------------------------------
module flex_counter_mul #(
   parameter int NUM_BITS = 4
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                clear,
   input  logic                count_enable,
   input  logic [NUM_BITS-1:0] rollover_val,
   output logic                rollover_flag
);

   logic [NUM_BITS-1:0] count_q, count_d;

   // NOTE: every signal written here gets a default first so no path leaves it
   // unassigned, which is what keeps combinational blocks from inferring latches.
   always_comb begin
      count_d       = count_q;
      rollover_flag = count_enable & ~clear & ((count_q + NUM_BITS'(1)) == rollover_val);
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = rollover_flag ? '0 : count_q + NUM_BITS'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of the order the processes execute.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule

// File: rtl/radix2_div32.sv
// -----------------------------------------------------------------------------
// radix2_div32
//   Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit
//   per cycle. Start/finished handshake matches the pipelined multiplier.
//   CLK, nRST  : clock (rising edge), asynchronous active-low reset
//   dividend   : numerator (rs1), sampled with start
//   divisor    : denominator (rs2), sampled with start
//   is_signed  : 1 = two's-complement operands (DIV/REM), 0 = unsigned
//   start      : 1-cycle request; a start while busy aborts the current op
//   finished   : 1-cycle pulse; quotient/remainder valid from this cycle
//   quotient   : result, held until the next completion
//   remainder  : result, held until the next completion
//   Build option: define DIV_EARLY_OUT_EN to skip the iterations when the
//   result is known up front (divide by zero, signed overflow, |divisor| >
//   |dividend|). Without it every operation takes WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module radix2_div32
   import rv32m_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   input  logic             start,
   output logic             finished,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_BITS = $clog2(WIDTH) + 1;

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic             op_signed_q, op_signed_d;
   logic [WIDTH-1:0] div_q, div_d, quo_q, quo_d, rem_q, rem_d;
   logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic             div_zero_q, div_zero_d, ovf_q, ovf_d;
   logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
   logic             finished_q, finished_d;

   logic             cnt_clear, cnt_en, cnt_roll;
   logic             a_neg, b_neg, is_zero, is_ovf;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   shifted_rem, trial;
`ifdef DIV_EARLY_OUT_EN
   logic             early_out;
`endif

   flex_counter_mul #(.NUM_BITS(CNT_BITS)) u_iter_cnt (
      .CLK          (CLK),
      .nRST         (nRST),
      .clear        (cnt_clear),
      .count_enable (cnt_en),
      .rollover_val (CNT_BITS'(WIDTH)),
      .rollover_flag(cnt_roll)
   );

   // Operand magnitudes and special-case flags, evaluated in INIT from the
   // operands captured with start.
   always_comb begin
      a_neg   = op_signed_q & op_a_q[WIDTH-1];
      b_neg   = op_signed_q & op_b_q[WIDTH-1];
      abs_a   = a_neg ? -op_a_q : op_a_q;
      abs_b   = b_neg ? -op_b_q : op_b_q;
      is_zero = (op_b_q == '0);
      is_ovf  = op_signed_q & (op_a_q == {1'b1, {(WIDTH-1){1'b0}}}) & (op_b_q == '1);
`ifdef DIV_EARLY_OUT_EN
      early_out = is_zero | is_ovf | (abs_b > abs_a);
`endif
   end

   // Restoring step: the partial remainder lives in WIDTH bits between
   // iterations (it is always below the divisor); only the shifted value and
   // the trial difference need the extra bit, whose MSB is the borrow.
   assign shifted_rem = {rem_q, quo_q[WIDTH-1]};
   assign trial       = shifted_rem - {1'b0, div_q};

   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_signed_d = op_signed_q;
      div_d       = div_q;
      quo_d       = quo_q;
      rem_d       = rem_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      div_zero_d  = div_zero_q;
      ovf_d       = ovf_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      finished_d  = 1'b0;
      cnt_clear   = 1'b0;
      cnt_en      = 1'b0;

      case (state_q)
         IDLE: ;
         INIT: begin
            div_d      = abs_b;
            quo_d      = abs_a;
            rem_d      = '0;
            q_neg_d    = a_neg ^ b_neg;
            r_neg_d    = a_neg;
            div_zero_d = is_zero;
            ovf_d      = is_ovf;
            cnt_clear  = 1'b1;
            state_d    = ITER;
`ifdef DIV_EARLY_OUT_EN
            if (early_out) begin
               state_d = DONE;
               // Preload the trivial result so DONE's sign fix-up returns
               // quotient 0 and the original dividend as remainder.
               if (abs_b > abs_a) begin
                  quo_d = '0;
                  rem_d = abs_a;
               end
            end
`endif
         end
         ITER: begin
            cnt_en = 1'b1;
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted_rem[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_roll) state_d = DONE;
         end
         DONE: begin
            finished_d = 1'b1;
            if (div_zero_q) begin
               quotient_d  = WIDTH'(DIV_ZERO_QUO);
               remainder_d = op_a_q;
            end else if (ovf_q) begin
               quotient_d  = WIDTH'(DIV_OVF_QUO);
               remainder_d = WIDTH'(DIV_OVF_REM);
            end else begin
               quotient_d  = q_neg_q ? -quo_q : quo_q;
               remainder_d = r_neg_q ? -rem_q : rem_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A new request always restarts; the DONE results above still register.
      if (start) begin
         state_d     = INIT;
         op_a_d      = dividend;
         op_b_d      = divisor;
         op_signed_d = is_signed;
      end
   end

   // NOTE: every datapath register is reset, not just the FSM, so an aborted
   // op leaves no stale operands or results behind after nRST.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_signed_q <= 1'b0;
         div_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         div_zero_q  <= 1'b0;
         ovf_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         finished_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_signed_q <= op_signed_d;
         div_q       <= div_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         div_zero_q  <= div_zero_d;
         ovf_q       <= ovf_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         finished_q  <= finished_d;
      end
   end

   assign finished  = finished_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_radix2_div32.sv
// -----------------------------------------------------------------------------
// tb_radix2_div32
//   Scoreboard bench for radix2_div32: the driver pushes the expected
//   quotient/remainder/completion cycle for each request; a monitor pops and
//   compares on every finished pulse. Honours DIV_EARLY_OUT_EN for latency.
// -----------------------------------------------------------------------------
module tb_radix2_div32;

   localparam int FULL_LAT = 34;
   localparam int EARLY_LAT = 2;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] dividend, divisor;
   logic        is_signed, start;
   logic        finished;
   logic [31:0] quotient, remainder;

   radix2_div32 dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .dividend (dividend),
      .divisor  (divisor),
      .is_signed(is_signed),
      .start    (start),
      .finished (finished),
      .quotient (quotient),
      .remainder(remainder)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          fin_cyc;
      string       name;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      logic [31:0] q;
      logic [31:0] r;
      string       name;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic bit early_case(input logic [31:0] a, input logic [31:0] b, input bit s);
      logic [31:0] ma, mb;
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      return EARLY_EN && ((b == 32'd0) ||
                          (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                          (mb > ma));
   endfunction

   // Monitor: compare on every finished pulse, and police the pulse width.
   logic prev_fin = 1'b0;
   exp_t got;
   always @(negedge CLK) begin
      if (nRST) begin
         if (prev_fin) check("finished_pulse_width", {31'b0, finished}, 32'd0);
         if (finished) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_finished: pulse at cycle %0d, expected none", cyc);
            end else begin
               got = sb.pop_front();
               check({got.name, "_quo"}, quotient, got.q);
               check({got.name, "_rem"}, remainder, got.r);
               check({got.name, "_cycle"}, 32'(cyc), 32'(got.fin_cyc));
            end
         end
      end
      prev_fin = finished;
   end

   // Call just after a falling edge; start is sampled at the next rising edge.
   task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit s,
                           input bit push, input logic [31:0] q, input logic [31:0] r,
                           input string name);
      exp_t e;
      dividend  = a;
      divisor   = b;
      is_signed = s;
      start     = 1'b1;
      if (push) begin
         e.q       = q;
         e.r       = r;
         e.fin_cyc = cyc + 1 + (early_case(a, b, s) ? EARLY_LAT : FULL_LAT);
         e.name    = name;
         sb.push_back(e);
      end
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge CLK);
         t++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
         sb.delete();
      end
      repeat (2) @(negedge CLK);
   endtask

   vec_t vecs[13] = '{
      '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          "u_100_7"},
      '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  "s_m7_2"},
      '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          "s_7_m2"},
      '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  "s_m100_m7"},
      '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          "u_5_0"},
      '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  "s_m5_0"},
      '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          "s_ovf"},
      '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  "u_ovf_ops"},
      '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          "u_3_10"},
      '{32'hFFFF_FFFD,  32'd10,         1'b1, 32'd0,          32'hFFFF_FFFD,  "s_m3_10"},
      '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          "u_max_1"},
      '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          "u_max_max"},
      '{32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0,          "s_min_2"}
   };

   int k_a;

   initial begin
      nRST      = 1'b0;
      start     = 1'b0;
      dividend  = '0;
      divisor   = '0;
      is_signed = 1'b0;
      repeat (2) @(negedge CLK);
      check("reset_quotient", quotient, 32'd0);
      check("reset_remainder", remainder, 32'd0);
      check("reset_finished", {31'b0, finished}, 32'd0);
      nRST = 1'b1;
      @(negedge CLK);

      foreach (vecs[i]) begin
         do_start(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, vecs[i].q, vecs[i].r, vecs[i].name);
         wait_drain(vecs[i].name);
      end

      // Abort: second start ten cycles into the first; only one result.
      do_start(32'd100, 32'd7, 1'b0, 1'b0, '0, '0, "");
      repeat (9) @(negedge CLK);
      do_start(32'd81, 32'd9, 1'b0, 1'b1, 32'd9, 32'd0, "abort_81_9");
      wait_drain("abort_81_9");

      // Start coincident with DONE: old result still reported, new op runs.
      k_a = cyc + 1;
      do_start(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, "done_old");
      while (cyc != k_a + 33) @(negedge CLK);
      do_start(32'd1000, 32'd10, 1'b0, 1'b1, 32'd100, 32'd0, "done_new");
      wait_drain("done_overlap");

      // Reset mid-operation: outputs clear at once and no pulse follows.
      do_start(32'd100, 32'd7, 1'b0, 1'b0, '0, '0, "");
      repeat (14) @(negedge CLK);
      nRST = 1'b0;
      #1;
      check("midreset_quotient", quotient, 32'd0);
      check("midreset_remainder", remainder, 32'd0);
      check("midreset_finished", {31'b0, finished}, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      repeat (40) @(negedge CLK);
      check("postreset_quotient", quotient, 32'd0);
      check("postreset_remainder", remainder, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
